// File: rtl/gcd_feeder_if.sv
// ----------------------------------------------------------------------------
// gcd_feeder_if
// Bundle of every handshake and bus signal around gcd_feeder.
//   Upstream  : in_valid / in_ready / in_opa / in_opb   (operand pair push)
//   GCD core  : gcd_opa / gcd_opb / gcd_start / gcd_resetn  (to core)
//               gcd_result / gcd_done                       (from core)
//   Consumer  : out_valid / out_ready / out_result / out_err
//   Status    : busy
// The slave modport is the feeder's view; the master modport is the view of
// the surrounding environment (upstream producer, gcd core and consumer).
// ----------------------------------------------------------------------------
interface gcd_feeder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_opa;
    logic [WIDTH-1:0] in_opb;

    logic [WIDTH-1:0] gcd_opa;
    logic [WIDTH-1:0] gcd_opb;
    logic             gcd_start;
    logic             gcd_resetn;
    logic [WIDTH-1:0] gcd_result;
    logic             gcd_done;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;

    logic             busy;

    modport slave (
        input  in_valid, in_opa, in_opb,
        input  gcd_result, gcd_done,
        input  out_ready,
        output in_ready,
        output gcd_opa, gcd_opb, gcd_start, gcd_resetn,
        output out_valid, out_result, out_err,
        output busy
    );

    modport master (
        output in_valid, in_opa, in_opb,
        output gcd_result, gcd_done,
        output out_ready,
        input  in_ready,
        input  gcd_opa, gcd_opb, gcd_start, gcd_resetn,
        input  out_valid, out_result, out_err,
        input  busy
    );
endinterface

// File: rtl/gcd_feeder.sv
// ----------------------------------------------------------------------------
// gcd_feeder
// Queues operand pairs in a small FIFO and feeds them one at a time to an
// external multi-cycle GCD core. Pairs with a zero operand are answered
// locally without starting the core. A watchdog aborts a core run that does
// not finish within TIMEOUT cycles. Results come out in push order.
//
// Ports
//   clk    : single clock, all state on the rising edge
//   reset  : synchronous, active-high
//   bus    : gcd_feeder_if.slave (upstream push, core control, result, busy)
//
// Timing
//   push at edge k, both operands non-zero : gcd_start high after edge k+2
//   push at edge k, a zero operand         : out_valid high after edge k+1
// ----------------------------------------------------------------------------
module gcd_feeder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    gcd_feeder_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    // ------------------------------------------------------------------
    // Operand FIFO. Pointers carry one extra bit so full and empty are
    // distinguishable when the index bits match.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;

    // ------------------------------------------------------------------
    // Control / datapath registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic [CW-1:0]    r_cnt;
    logic             r_start;

    logic             w_head_a_zero;
    logic             w_head_b_zero;
    logic             w_cnt_last;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // in_ready depends only on the registered fill level, so a pop in the
    // same cycle cannot open the input while the FIFO is full.
    assign w_push   = bus.in_valid && !w_full;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;

    assign w_head_a = r_mem_a[r_rd_ptr[AW-1:0]];
    assign w_head_b = r_mem_b[r_rd_ptr[AW-1:0]];

    assign w_head_a_zero = (w_head_a == '0);
    assign w_head_b_zero = (w_head_b == '0);
    assign w_cnt_last    = (r_cnt == CNT_LAST);

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr[AW-1:0]] <= bus.in_opa;
            r_mem_b[r_wr_ptr[AW-1:0]] <= bus.in_opb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head_a_zero || w_head_b_zero) begin
                        w_state_next = S_RESULT;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.gcd_done || w_cnt_last) begin
                    w_state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_start  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Start is registered out of ISSUE, so it is high for exactly
            // the first WAIT cycle; operands are already stable by then.
            r_start <= (r_state == S_ISSUE);

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_opa <= w_head_a;
                        r_opb <= w_head_b;
                        if (w_head_a_zero && w_head_b_zero) begin
                            r_result <= '0;
                            r_err    <= 1'b1;
                        end else if (w_head_a_zero) begin
                            r_result <= w_head_b;
                            r_err    <= 1'b0;
                        end else if (w_head_b_zero) begin
                            r_result <= w_head_a;
                            r_err    <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still wins.
                    if (bus.gcd_done) begin
                        r_result <= bus.gcd_result;
                        r_err    <= 1'b0;
                    end else if (w_cnt_last) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = !w_full;
    assign bus.gcd_opa    = r_opa;
    assign bus.gcd_opb    = r_opb;
    assign bus.gcd_start  = r_start;
    assign bus.gcd_resetn = ~reset;
    assign bus.out_valid  = (r_state == S_RESULT);
    assign bus.out_result = r_result;
    assign bus.out_err    = r_err;
    assign bus.busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_gcd_feeder.sv
// ----------------------------------------------------------------------------
// tb_gcd_feeder
// Directed bench for gcd_feeder (WIDTH=32, DEPTH=4, TIMEOUT=16) with a
// behavioural GCD core that answers a fixed number of cycles after start.
// ----------------------------------------------------------------------------
module tb_gcd_feeder;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gcd_feeder_if #(.WIDTH(W)) bus ();

    gcd_feeder #(.WIDTH(W), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ------------------------------------------------------------------
    // Behavioural GCD core
    // ------------------------------------------------------------------
    int         m_delay   = 10;
    bit         m_enable  = 1'b1;
    int         m_cnt     = 0;
    logic       m_done    = 1'b0;
    logic [W-1:0] m_res   = '0;
    logic [W-1:0] cap_a   = '0;
    logic [W-1:0] cap_b   = '0;
    int         start_cnt = 0;
    int         opa_moved = 0;
    logic       tb_done   = 1'b0;
    logic [W-1:0] tb_res  = '0;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (reset) begin
            m_cnt <= 0;
        end else begin
            if (bus.gcd_start) begin
                start_cnt <= start_cnt + 1;
                cap_a     <= bus.gcd_opa;
                cap_b     <= bus.gcd_opb;
                m_cnt     <= m_delay;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && m_enable) begin
                    m_done <= 1'b1;
                    m_res  <= gcd_ref(cap_a, cap_b);
                end
            end
            if (m_cnt > 0 && (bus.gcd_opa != cap_a || bus.gcd_opb != cap_b))
                opa_moved <= opa_moved + 1;
        end
    end

    assign bus.gcd_done   = m_done | tb_done;
    assign bus.gcd_result = m_done ? m_res : tb_res;

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_opa   = a;
        bus.in_opb   = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic take(input string name, input logic [W-1:0] er, input logic ee);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_res"}, bus.out_result, er);
        chk({name, "_err"}, bus.out_err, ee);
        $display("txn %s: result %0d err %0d (expect %0d/%0d)", name, bus.out_result, bus.out_err, er, ee);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_drop"}, bus.out_valid, 0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         err;
        int           starts;
    } vec_t;

    vec_t vecs[7];
    logic [W-1:0] fa[6];
    logic [W-1:0] fb[6];
    logic [W-1:0] fr[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int n;
        int acc;
        logic r;

        vecs[0] = '{a: 1071, b: 462, res: 21,  err: 1'b0, starts: 1};
        vecs[1] = '{a: 0,    b: 255, res: 255, err: 1'b0, starts: 0};
        vecs[2] = '{a: 0,    b: 0,   res: 0,   err: 1'b1, starts: 0};
        vecs[3] = '{a: 255,  b: 0,   res: 255, err: 1'b0, starts: 0};
        vecs[4] = '{a: 48,   b: 18,  res: 6,   err: 1'b0, starts: 1};
        vecs[5] = '{a: 17,   b: 13,  res: 1,   err: 1'b0, starts: 1};
        vecs[6] = '{a: 100,  b: 100, res: 100, err: 1'b0, starts: 1};

        fa = '{1075, 12, 0, 81, 35, 9};
        fb = '{255,  8,  7, 27, 64, 6};
        fr = '{5,    4,  7, 27, 1};

        bus.in_valid  = 1'b0;
        bus.in_opa    = '0;
        bus.in_opb    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_gcd_start", bus.gcd_start, 0);
        chk("rst_gcd_opa", bus.gcd_opa, 0);
        chk("rst_gcd_opb", bus.gcd_opb, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gcd_resetn", bus.gcd_resetn, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_gcd_resetn", bus.gcd_resetn, 1);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            s0 = start_cnt;
            push(vecs[i].a, vecs[i].b);
            take($sformatf("vec%0d", i), vecs[i].res, vecs[i].err);
            chk($sformatf("vec%0d_starts", i), start_cnt - s0, vecs[i].starts);
        end

        // Bypass latency: out_valid after edge k+1
        s0 = start_cnt;
        push(0, 255);
        @(negedge clk);
        chk("byp_early", bus.out_valid, 0);
        @(negedge clk);
        chk("byp_latency", bus.out_valid, 1);
        take("bypass", 255, 0);
        chk("byp_starts", start_cnt - s0, 0);

        // Issue latency: gcd_start high only in the cycle after edge k+2
        push(48, 18);
        @(negedge clk);
        chk("iss_k0", bus.gcd_start, 0);
        @(negedge clk);
        chk("iss_k1", bus.gcd_start, 0);
        @(negedge clk);
        chk("iss_k2", bus.gcd_start, 1);
        @(negedge clk);
        chk("iss_k3", bus.gcd_start, 0);
        take("issue", 6, 0);

        // Backpressure: 1 in RESULT + 4 queued, sixth pair refused
        m_delay = 3;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            r = bus.in_ready;
            bus.in_valid = 1'b1;
            bus.in_opa   = fa[i];
            bus.in_opb   = fb[i];
            @(posedge clk);
            #1;
            if (r) acc++;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_accepted", acc, 5);
        for (int i = 0; i < 5; i++) begin
            take($sformatf("fifo%0d", i), fr[i], 0);
        end
        chk("fifo_busy_after", bus.busy, 0);
        chk("fifo_no_extra", bus.out_valid, 0);

        // Timeout: core never answers
        m_enable = 1'b0;
        push(48, 36);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.gcd_start && n < 50);
        chk("to_start_seen", bus.gcd_start, 1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, 16);
        take("timeout", 0, 1);
        m_enable = 1'b1;
        m_delay  = 10;
        push(1071, 462);
        take("after_timeout", 21, 0);

        // Reset while waiting with two pairs queued
        m_delay = 40;
        push(12, 8);
        push(9, 6);
        push(5, 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.gcd_start && n < 50);
        chk("mid_start_seen", bus.gcd_start, 1);
        repeat (3) @(negedge clk);
        chk("mid_busy_before", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_resetn_low", bus.gcd_resetn, 0);
        reset = 1'b0;
        s0 = start_cnt;
        tb_res  = 99;
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("mid_no_out_valid", n, 0);
        chk("mid_busy", bus.busy, 0);
        chk("mid_in_ready", bus.in_ready, 1);
        chk("mid_starts", start_cnt - s0, 0);
        m_delay = 10;
        push(1071, 462);
        take("after_reset", 21, 0);

        chk("opa_stable", opa_moved, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/gcd_feeder.md
GCD_FEEDER -- requirements
Module: gcd_feeder

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: DEPTH, 4, operand-pair FIFO entries (power of 2, >=2).
REQ-003 Parameter: TIMEOUT, 1024, max cycles waited for gcd_done before abort.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: in_valid  in  1  upstream operand pair valid.
REQ-007 Port: in_ready  out  1  FIFO can accept a pair this cycle.
REQ-008 Port: in_opa / in_opb  in  WIDTH  operand pair.
REQ-009 Port: gcd_opa / gcd_opb  out  WIDTH  operands to downstream gcd core; stable from start through done.
REQ-010 Port: gcd_start  out  1  one-cycle start pulse to gcd core.
REQ-011 Port: gcd_resetn  out  1  active-low reset to gcd core, combinationally equal to NOT reset.
REQ-012 Port: gcd_result  in  WIDTH  gcd core result, valid when gcd_done=1.
REQ-013 Port: gcd_done  in  1  gcd core completion.
REQ-014 Port: out_valid  out  1  result available.
REQ-015 Port: out_ready  in  1  consumer accepts result.
REQ-016 Port: out_result  out  WIDTH  GCD of the pair.
REQ-017 Port: out_err  out  1  result invalid (both operands zero, or timeout).
REQ-018 Port: busy  out  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-019 Push when in_valid && in_ready; in_ready = NOT full; a pop in the same cycle does not raise in_ready while full.
REQ-020 FIFO order strictly preserved; results emitted in push order, one per pair.
REQ-021 FSM states IDLE, ISSUE, WAIT, RESULT.
REQ-022 IDLE: if FIFO non-empty, pop head into operand registers; if exactly one operand is zero -> RESULT with out_result = other operand, out_err=0; if both zero -> RESULT with out_result=0, out_err=1; else -> ISSUE.
REQ-023 ISSUE: gcd_start=1 for exactly one cycle, wait counter cleared -> WAIT.
REQ-024 WAIT: gcd_start=0; on gcd_done=1 capture gcd_result into out_result, out_err=0 -> RESULT.
REQ-025 WAIT: counter increments each cycle without done; when it reaches TIMEOUT-1 without done -> RESULT with out_result=0, out_err=1.
REQ-026 gcd_done in same cycle as timeout takes priority (valid result, out_err=0).
REQ-027 gcd_done outside WAIT is ignored.
REQ-028 RESULT: out_valid=1, out_result/out_err held stable until out_ready=1; on handshake -> IDLE.
REQ-029 Latency (no backpressure, non-zero operands): pair pushed at edge k -> gcd_start high in cycle after edge k+2; out_valid high cycle after the edge sampling gcd_done.
REQ-030 Bypass latency: pair pushed at edge k with a zero operand -> out_valid high after edge k+1; gcd_start never asserted.
REQ-031 gcd_opa/gcd_opb driven from operand registers, unchanged from ISSUE until FSM leaves WAIT.
REQ-032 FIFO pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or count.

Reset
REQ-033 With reset=1 at a rising edge: FIFO emptied, FSM to IDLE, counter 0, operand/result registers 0.
REQ-034 Outputs during/after reset: in_ready=1 (after reset deasserts), out_valid=0, out_result=0, out_err=0, gcd_start=0, gcd_opa=gcd_opb=0, busy=0, gcd_resetn=0 while reset=1.
REQ-035 Reset mid-operation (any state) aborts the pair in flight and discards queued pairs; no result emitted for them.

Verification
REQ-036 Push (1071,462), gcd model returns 21 after 10 cycles -> one gcd_start pulse, out_result=21, out_err=0.
REQ-037 Push (0,255) -> no gcd_start, out_valid after edge k+1, out_result=255, out_err=0.
REQ-038 Push (0,0) -> no gcd_start, out_result=0, out_err=1.
REQ-039 out_ready held 0, push 6 pairs back-to-back incl. (1075,255) first -> in_ready drops after 5th accepted (1 in RESULT + 4 queued); release -> results in order, first 5.
REQ-040 gcd model never asserts done, TIMEOUT=16 -> out_valid exactly 16 cycles after WAIT entry, out_result=0, out_err=1; next pair proceeds normally.
REQ-041 reset pulsed for one cycle while in WAIT with 2 pairs queued, then gcd_done pulsed -> done ignored, no out_valid, busy=0, in_ready=1.
